mem_access: RTL
===============

# mem_access

Memory-access stage sitting directly downstream of the execute stage in the single-issue MIPS pipeline. Consumes the execute result (effective address for loads/stores, pass-through value otherwise) plus the store operand, drives a variable-latency data-memory request/acknowledge interface, and produces the write-back value. Performs byte-lane generation for stores, lane extraction and sign/zero extension for loads, and holds the pipeline via `stall` while a memory transaction is outstanding.

## Interface
- No parameters; data and address width fixed at 32.
- `sys_clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `valid` in 1: EX/MEM register holds a live instruction.
- `opcode` in 6: primary opcode of that instruction.
- `is_load_store` in 1: instruction is a load or store.
- `alu_result` in 32: execute result; effective address when `is_load_store`.
- `store_data` in 32: rt operand for stores.
- `mem_req` out 1: request to data memory.
- `mem_we` out 1: request is a write.
- `mem_addr` out 32: word-aligned address, `{alu_result[31:2],2'b00}`.
- `mem_be` out 4: byte enables, bit i = byte lane i (little-endian).
- `mem_wdata` out 32: lane-replicated store data.
- `mem_rdata` in 32: read data, valid when `mem_ack`=1.
- `mem_ack` in 1: memory completes the current request.
- `wb_data` out 32: value passed to write-back.
- `stall` out 1: hold all upstream stages this cycle.
- `addr_err` out 1: misaligned access detected.
- `bad_vaddr` out 32: offending address when `addr_err`=1.

## Operation
- Supported opcodes: lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101, sb 101000, sh 101001, sw 101011. Any other opcode with `is_load_store`=1 is treated as a non-memory pass-through.
- Non-memory instruction, or `valid`=0: `wb_data`=`alu_result` combinationally, `stall`=0, and the FSM stays in IDLE.
- FSM states: IDLE, REQ, DONE.
  - IDLE -> REQ: `valid` and a memory opcode and the access is aligned. `stall`=1 in this accept cycle.
  - IDLE -> DONE: misaligned access; no request is issued and the fault is latched.
  - REQ -> DONE: at the first edge with `mem_ack`=1. `mem_rdata` is captured into the load register at that edge.
  - REQ -> REQ: while `mem_ack`=0.
  - DONE -> IDLE: unconditional. Re-triggering from DONE is impossible because the same instruction is still presented.
- `mem_req`=1 exactly while in REQ. `mem_we`, `mem_addr`, `mem_be` and `mem_wdata` are registered at the IDLE->REQ edge and held stable throughout REQ.
- `stall`=1 in IDLE (accept cycle) and in REQ. `stall`=0 in DONE, so the instruction advances at the end of DONE.
- Store lanes:
  - sb: `mem_be` = 1<<addr[1:0], `mem_wdata` = {4{d[7:0]}}.
  - sh: `mem_be` = addr[1] ? 1100 : 0011, `mem_wdata` = {2{d[15:0]}}.
  - sw: `mem_be` = 1111, `mem_wdata` = d.
- Loads: `mem_be` = 1111. In DONE, lanes are selected from the captured word by addr[1:0] (byte) or addr[1] (half):
  - lb and lh sign-extend.
  - lbu and lhu zero-extend.
  - lw passes the word through.
- `wb_data` in DONE: the extended load value; 0 for stores and for faulted accesses.
- `mem_ack` is ignored outside REQ.

## Timing
- Reset values: state IDLE, `mem_req`=0, `mem_we`=0, `mem_be`=0, `mem_wdata`=0, `mem_addr`=0, load register 0, `addr_err`=0, `bad_vaddr`=0. `stall` and `wb_data` follow from IDLE with `valid` low (0).
- Minimum memory latency is 3 cycles (accept, REQ with ack, DONE), with `stall` high for 2 of them. Each extra wait cycle adds one REQ cycle.
- `rst` asserted mid-REQ: FSM returns to IDLE at that edge and `mem_req` drops. Memory treats deassertion of `mem_req` without ack as cancel.
- `addr_err` is high exactly in DONE of a faulted access; `bad_vaddr` is held until the next fault or reset.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined: misalignment is detected as follows.
  - lh, lhu, sh: addr[0]≠0.
  - lw, sw: addr[1:0]≠0.
  - A misaligned access takes IDLE->DONE with `addr_err`=1, `bad_vaddr`=`alu_result`, and no memory request.
- Undefined: `addr_err` tied to 0 and `bad_vaddr` tied to 0. The ignored low address bits are treated as zero (half uses addr[1] only; word ignores addr[1:0]), and every memory opcode goes through REQ.

## Test plan
- lb at 0x1003, memory word 0x80112233, ack in first REQ cycle -> `stall` 1,1,0; DONE `wb_data`=0xFFFFFF80. Same stimulus with lbu -> 0x00000080.
- sh at 0x2002, `store_data`=0x1234ABCD -> `mem_req`=1, `mem_we`=1, `mem_addr`=0x2000, `mem_be`=1100, `mem_wdata`=0xABCDABCD; `wb_data`=0 in DONE.
- lw at 0x3000 with ack delayed 4 cycles -> `stall` high for 6 consecutive cycles, then DONE returns the captured `mem_rdata`; a stray `mem_ack` in DONE or IDLE has no effect.
- Add instruction with `alu_result`=0x55 -> `wb_data`=0x55 in the same cycle, `stall`=0, `mem_req` never asserted.
- With `MEM_ALIGN_CHECK_EN`: lw at 0x4002 -> no `mem_req`, `addr_err`=1 in DONE, `bad_vaddr`=0x4002. Without it: request issued to 0x4000 with `mem_be`=1111.
- `rst` pulsed during REQ of sw at 0x5000 -> `mem_req`=0 on the next edge, FSM in IDLE, all outputs at reset values.

Source files
------------

// File: rtl/mem_access.sv
// mem_access: memory-access stage of the single-issue MIPS pipeline.
// Takes the execute result (effective address or pass-through value) and
// the store operand, runs one variable-latency request/acknowledge data
// memory transaction per load/store, generates byte lanes for stores and
// extracts/extends lanes for loads, and holds upstream stages via stall.
//
// Handshake: mem_req is high exactly while the FSM is in REQ; the request
// fields (mem_we, mem_addr, mem_be, mem_wdata) are registered on entry to
// REQ and held stable until the next accept. The transaction completes on
// the first rising edge where mem_req=1 and mem_ack=1; mem_ack at any other
// time is ignored, and dropping mem_req without an ack means cancel.
//
// Optional feature: define MEM_ALIGN_CHECK_EN to detect misaligned
// half/word accesses, which then fault (addr_err/bad_vaddr) instead of
// issuing a request. Without it the ignored low address bits are treated
// as zero and addr_err/bad_vaddr stay 0.
module mem_access (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [5:0]  opcode,
  input  logic        is_load_store,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] wb_data,
  output logic        stall,
  output logic        addr_err,
  output logic [31:0] bad_vaddr,
  output logic [1:0]  dbg_state
);

  // Primary opcodes of the supported loads and stores.
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q,     state_d;
  logic        mem_req_q,   mem_req_d;
  logic        mem_we_q,    mem_we_d;
  logic [31:0] mem_addr_q,  mem_addr_d;
  logic [3:0]  mem_be_q,    mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] load_q,      load_d;
  logic [5:0]  op_q,        op_d;
  logic [1:0]  lo_q,        lo_d;
  logic        addr_err_q,  addr_err_d;
  logic [31:0] bad_vaddr_q, bad_vaddr_d;

  logic        is_load_op;
  logic        is_store_op;
  logic        is_mem;
  logic        misaligned;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // Classify the presented opcode; unknown opcodes are pass-through.
  always_comb begin
    is_load_op  = 1'b0;
    is_store_op = 1'b0;
    case (opcode)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: is_load_op  = 1'b1;
      OP_SB, OP_SH, OP_SW:                 is_store_op = 1'b1;
      default: ;
    endcase
    is_mem = valid & is_load_store & (is_load_op | is_store_op);
  end

  // Alignment fault detection for the presented access.
  always_comb begin
    misaligned = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    case (opcode)
      OP_LH, OP_LHU, OP_SH: misaligned = alu_result[0];
      OP_LW, OP_SW:         misaligned = |alu_result[1:0];
      default: ;
    endcase
`endif
  end

  // Byte enables and lane-replicated write data; loads read the full word.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = store_data;
    case (opcode)
      OP_SB: begin
        st_be    = 4'b0001 << alu_result[1:0];
        st_wdata = {4{store_data[7:0]}};
      end
      OP_SH: begin
        st_be    = alu_result[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Next-state and next-output logic of the access FSM.
  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    load_d      = load_q;
    op_d        = op_q;
    lo_d        = lo_q;
    addr_err_d  = addr_err_q;
    bad_vaddr_d = bad_vaddr_q;
    case (state_q)
      S_IDLE: begin
        if (is_mem) begin
          // Remember which lanes to pick once the data comes back.
          op_d = opcode;
          lo_d = alu_result[1:0];
          if (misaligned) begin
            state_d     = S_DONE;
            addr_err_d  = 1'b1;
            bad_vaddr_d = alu_result;
          end else begin
            state_d     = S_REQ;
            mem_we_d    = is_store_op;
            mem_addr_d  = {alu_result[31:2], 2'b00};
            mem_be_d    = st_be;
            mem_wdata_d = st_wdata;
          end
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          load_d  = mem_rdata;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // The same instruction is still presented here, so never re-accept.
        state_d    = S_IDLE;
        addr_err_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    mem_req_d = (state_d == S_REQ);
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
      load_q      <= 32'd0;
      op_q        <= 6'd0;
      lo_q        <= 2'd0;
      addr_err_q  <= 1'b0;
      bad_vaddr_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      load_q      <= load_d;
      op_q        <= op_d;
      lo_q        <= lo_d;
      addr_err_q  <= addr_err_d;
      bad_vaddr_q <= bad_vaddr_d;
    end
  end

  // Lane extraction and sign/zero extension of the captured load word.
  always_comb begin
    case (lo_q)
      2'd0:    ld_byte = load_q[7:0];
      2'd1:    ld_byte = load_q[15:8];
      2'd2:    ld_byte = load_q[23:16];
      default: ld_byte = load_q[31:24];
    endcase
    ld_half = lo_q[1] ? load_q[31:16] : load_q[15:0];
    ld_ext  = 32'd0;
    case (op_q)
      OP_LB:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU: ld_ext = {24'd0, ld_byte};
      OP_LH:  ld_ext = {{16{ld_half[15]}}, ld_half};
      OP_LHU: ld_ext = {16'd0, ld_half};
      OP_LW:  ld_ext = load_q;
      default: ;
    endcase
  end

  // Write-back value and pipeline hold, decoded from the current state.
  always_comb begin
    wb_data = 32'd0;
    stall   = 1'b0;
    case (state_q)
      S_IDLE: begin
        wb_data = alu_result;
        stall   = is_mem;
      end
      S_REQ: begin
        stall = 1'b1;
      end
      S_DONE: begin
        wb_data = addr_err_q ? 32'd0 : ld_ext;
      end
      default: ;
    endcase
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign addr_err  = addr_err_q;
  assign bad_vaddr = bad_vaddr_q;
  assign dbg_state = state_q;

endmodule
